// File: rtl/mimc_round_engine_if.sv
// Purpose : bundles the mimc_round_engine request/result and multiplier signals.
// Latency : none, wiring only.
// Backpressure: start is only taken while ready=1; the multiplier side has no stall.
// Ports: start/ready/x_in/key_in (request), round_idx/round_const (constant lookup),
//        mul_a/mul_b/mul_p (external modular multiplier), dout/done (result).
interface mimc_round_engine_if #(
  parameter int N_BITS   = 254,
  parameter int N_ROUNDS = 110
);
  localparam int IDX_W = (N_ROUNDS > 1) ? $clog2(N_ROUNDS) : 1;

  logic              start;
  logic              ready;
  logic [N_BITS-1:0] x_in;
  logic [N_BITS-1:0] key_in;
  logic [IDX_W-1:0]  round_idx;
  logic [N_BITS-1:0] round_const;
  logic [N_BITS-1:0] mul_a;
  logic [N_BITS-1:0] mul_b;
  logic [N_BITS-1:0] mul_p;
  logic [N_BITS-1:0] dout;
  logic              done;

  // Engine side.
  modport slave (
    input  start, x_in, key_in, round_const, mul_p,
    output ready, round_idx, mul_a, mul_b, dout, done
  );

  // Requester / environment side.
  modport master (
    output start, x_in, key_in, round_const, mul_p,
    input  ready, round_idx, mul_a, mul_b, dout, done
  );
endinterface

// File: rtl/mimc_round_engine.sv
// Purpose : MiMC-5 permutation x -> (t^5 rounds) -> x + k over GF(P), multiplies on an external pipelined multiplier.
// Latency : N_ROUNDS*(2+3*(MULT_LATENCY+1))+2 clocks from accepting edge to done.
// Backpressure: single job in flight; ready=1 only when idle, start while busy is ignored.
// Ports: clk, rst_n (async active-low), bus (mimc_round_engine_if.slave: request, constant lookup,
//        multiplier operands/product, result with one-cycle done pulse).
// Option: define MIMC_FEEDFORWARD_EN to add the latched plaintext into the final output.
module mimc_round_engine #(
  parameter int                N_BITS       = 254,
  parameter int                N_ROUNDS     = 110,
  parameter int                MULT_LATENCY = 4,
  parameter logic [N_BITS-1:0] P            =
    N_BITS'(256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001)
) (
  input logic                clk,
  input logic                rst_n,
  mimc_round_engine_if.slave bus
);

  localparam int IDX_W = (N_ROUNDS > 1) ? $clog2(N_ROUNDS) : 1;
  localparam int CNT_W = (MULT_LATENCY > 0) ? $clog2(MULT_LATENCY + 1) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ROUNDS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULT_LATENCY);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADD_K = 3'd1;
  localparam logic [2:0] S_ADD_C = 3'd2;
  localparam logic [2:0] S_SQ1   = 3'd3;
  localparam logic [2:0] S_SQ2   = 3'd4;
  localparam logic [2:0] S_MUL5  = 3'd5;
  localparam logic [2:0] S_FINAL = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  // Operands are always < P, so a single conditional subtract reduces the sum.
  function automatic logic [N_BITS-1:0] mod_add(input logic [N_BITS-1:0] a,
                                                input logic [N_BITS-1:0] b);
    logic [N_BITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[N_BITS-1:0];
  endfunction

  logic [2:0]        state_q, state_d;
  logic [N_BITS-1:0] x_q, x_d;       // plaintext, then running round output
  logic [N_BITS-1:0] k_q, k_d;
  logic [N_BITS-1:0] t_q, t_d;       // round input t, kept for the final t^4*t
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;   // multiplier wait counter
  logic [N_BITS-1:0] mul_a_q, mul_a_d;
  logic [N_BITS-1:0] mul_b_q, mul_b_d;
  logic [N_BITS-1:0] dout_q, dout_d;
  logic              done_q, done_d;
  logic [N_BITS-1:0] add_c_sum;
`ifdef MIMC_FEEDFORWARD_EN
  logic [N_BITS-1:0] x0_q, x0_d;     // original plaintext for the feed-forward
`endif

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    k_d       = k_q;
    t_d       = t_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    dout_d    = dout_q;
    done_d    = 1'b0;
    add_c_sum = mod_add(t_q, bus.round_const);
`ifdef MIMC_FEEDFORWARD_EN
    x0_d      = x0_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          x_d     = bus.x_in;
          k_d     = bus.key_in;
          idx_d   = '0;
          state_d = S_ADD_K;
`ifdef MIMC_FEEDFORWARD_EN
          x0_d    = bus.x_in;
`endif
        end
      end
      S_ADD_K: begin
        t_d     = mod_add(x_q, k_q);
        state_d = S_ADD_C;
      end
      S_ADD_C: begin
        // Present t to the multiplier in the same edge t is stored.
        t_d     = add_c_sum;
        mul_a_d = add_c_sum;
        mul_b_d = add_c_sum;
        cnt_d   = '0;
        state_d = S_SQ1;
      end
      S_SQ1: begin
        if (cnt_q == CNT_LAST) begin
          mul_a_d = bus.mul_p;              // t^2 * t^2
          mul_b_d = bus.mul_p;
          cnt_d   = '0;
          state_d = S_SQ2;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SQ2: begin
        if (cnt_q == CNT_LAST) begin
          mul_a_d = bus.mul_p;              // t^4 * t
          mul_b_d = t_q;
          cnt_d   = '0;
          state_d = S_MUL5;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_MUL5: begin
        if (cnt_q == CNT_LAST) begin
          x_d   = bus.mul_p;
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = S_FINAL;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_ADD_K;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FINAL: begin
`ifdef MIMC_FEEDFORWARD_EN
        dout_d = mod_add(mod_add(x_q, k_q), x0_q);
`else
        dout_d = mod_add(x_q, k_q);
`endif
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      k_q     <= '0;
      t_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
`ifdef MIMC_FEEDFORWARD_EN
      x0_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      k_q     <= k_d;
      t_q     <= t_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
`ifdef MIMC_FEEDFORWARD_EN
      x0_q    <= x0_d;
`endif
    end
  end

  assign bus.ready     = (state_q == S_IDLE);
  assign bus.round_idx = idx_q;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.dout      = dout_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_mimc_round_engine.sv
// Purpose : checks mimc_round_engine instances (1, 2 and 5 rounds) against an arithmetic MiMC model.
// Latency : expects done exactly rounds*(2+3*(lat+1))+2 edges after the accepting edge.
// Backpressure: start is offered only when ready; one held-start run checks it is ignored while busy.
module tb_mimc_round_engine;

  localparam int NB = 254;
  localparam logic [NB-1:0] P =
    254'(256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  longint cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus-side arrays, one slot per DUT instance.
  logic          start_a [3];
  logic [NB-1:0] x_a     [3];
  logic [NB-1:0] k_a     [3];
  logic [NB-1:0] rc_tab  [3][8];
  bit            pin_vld [3];
  logic [NB-1:0] pin_val [3];
  int            pin_lat [3];

  // Observed outputs.
  logic          ready_a [3];
  logic          done_a  [3];
  logic [NB-1:0] dout_a  [3];
  logic [NB-1:0] mula_a  [3];
  logic [NB-1:0] mulb_a  [3];
  logic [7:0]    idx_a   [3];

  function automatic int nr(input int i);
    return (i == 0) ? 1 : (i == 1) ? 2 : 5;
  endfunction
  function automatic int lt(input int i);
    return (i == 2) ? 2 : 4;
  endfunction

  // Field arithmetic done with plain wide integer remainders.
  function automatic logic [NB-1:0] addm(input logic [NB-1:0] a, input logic [NB-1:0] b);
    logic [NB:0] s;
    s = ({1'b0, a} + {1'b0, b}) % {1'b0, P};
    return s[NB-1:0];
  endfunction
  function automatic logic [NB-1:0] mulm(input logic [NB-1:0] a, input logic [NB-1:0] b);
    logic [2*NB-1:0] pr;
    pr = ({{NB{1'b0}}, a} * {{NB{1'b0}}, b}) % {{NB{1'b0}}, P};
    return pr[NB-1:0];
  endfunction
  function automatic logic [NB-1:0] pow5(input logic [NB-1:0] t);
    logic [NB-1:0] r;
    r = 1;
    for (int n = 0; n < 5; n++) r = mulm(r, t);
    return r;
  endfunction
  function automatic logic [NB-1:0] model(input int i, input logic [NB-1:0] x0,
                                          input logic [NB-1:0] k);
    logic [NB-1:0] x;
    x = x0;
    for (int r = 0; r < nr(i); r++) x = pow5(addm(addm(x, k), rc_tab[i][r]));
    x = addm(x, k);
`ifdef MIMC_FEEDFORWARD_EN
    x = addm(x, x0);
`endif
    return x;
  endfunction
  function automatic logic [NB-1:0] rnd();
    logic [255:0] r;
    r = '0;
    for (int n = 0; n < 8; n++) r = {r[223:0], 32'($urandom)};
    r = r % {2'b00, P};
    return r[NB-1:0];
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NRG = (g == 0) ? 1 : (g == 1) ? 2 : 5;
    localparam int LTG = (g == 2) ? 2 : 4;
    mimc_round_engine_if #(.N_BITS(NB), .N_ROUNDS(NRG)) ifc ();
    mimc_round_engine #(.N_BITS(NB), .N_ROUNDS(NRG), .MULT_LATENCY(LTG), .P(P)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(ifc)
    );
    // Pipelined multiplier: product of operands seen in a cycle appears LTG cycles later.
    logic [NB-1:0] pipe [LTG];
    always @(posedge clk) begin
      pipe[0] <= mulm(ifc.mul_a, ifc.mul_b);
      for (int j = 1; j < LTG; j++) pipe[j] <= pipe[j-1];
    end
    assign ifc.mul_p       = pipe[LTG-1];
    assign ifc.start       = start_a[g];
    assign ifc.x_in        = x_a[g];
    assign ifc.key_in      = k_a[g];
    assign ifc.round_const = rc_tab[g][ifc.round_idx];
    assign ready_a[g]      = ifc.ready;
    assign done_a[g]       = ifc.done;
    assign dout_a[g]       = ifc.dout;
    assign mula_a[g]       = ifc.mul_a;
    assign mulb_a[g]       = ifc.mul_b;
    assign idx_a[g]        = 8'(ifc.round_idx);
  end

  // Scoreboard state, written only by the compare process.
  bit            busy     [3];
  logic [NB-1:0] exp_d    [3];
  logic [NB-1:0] held     [3];
  longint        acc_edge [3];
  logic [7:0]    seen     [3];

  task automatic chk(input string nm, input int i, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h expected %0h at cycle %0d", nm, i, act, req, cyc);
    end
  endtask

  // Compare process: on the falling edge, a done seen here belongs to the next rising edge.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      #1;
      for (int i = 0; i < 3; i++) begin
        chk("rst_ready", i, 256'(ready_a[i]), 256'd1);
        chk("rst_done",  i, 256'(done_a[i]),  256'd0);
        chk("rst_dout",  i, 256'(dout_a[i]),  256'd0);
        chk("rst_idx",   i, 256'(idx_a[i]),   256'd0);
        chk("rst_mul_a", i, 256'(mula_a[i]),  256'd0);
        chk("rst_mul_b", i, 256'(mulb_a[i]),  256'd0);
        busy[i] = 1'b0;
        held[i] = '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        chk("ready", i, 256'(ready_a[i]), 256'(!busy[i]));
        if (ready_a[i]) chk("idle_idx", i, 256'(idx_a[i]), 256'd0);
        checks++;
        if (idx_a[i] > 8'(nr(i) - 1)) begin
          errors++;
          $display("FAIL idx_range inst%0d: got %0d max %0d", i, idx_a[i], nr(i) - 1);
        end
        if (busy[i]) seen[i][idx_a[i][2:0]] = 1'b1;
        if (done_a[i]) begin
          chk("done_expected", i, 256'(busy[i]), 256'd1);
          if (busy[i]) begin
            chk("latency", i, 256'(cyc + 1 - acc_edge[i]),
                256'(nr(i) * (2 + 3 * (lt(i) + 1)) + 2));
            if (pin_vld[i]) chk("latency_pin", i, 256'(cyc + 1 - acc_edge[i]), 256'(pin_lat[i]));
            chk("dout", i, 256'(dout_a[i]), 256'(exp_d[i]));
            chk("idx_seq", i, 256'(seen[i]), 256'((1 << nr(i)) - 1));
            held[i] = exp_d[i];
            busy[i] = 1'b0;
          end
        end else begin
          chk("dout_hold", i, 256'(dout_a[i]), 256'(held[i]));
          if (busy[i] && (cyc + 1 - acc_edge[i]) > longint'(nr(i) * (2 + 3 * (lt(i) + 1)) + 2)) begin
            chk("done_timeout", i, 256'd0, 256'd1);
            busy[i] = 1'b0;
          end
        end
        if (ready_a[i] && start_a[i]) begin
          busy[i]     = 1'b1;
          acc_edge[i] = cyc + 1;
          seen[i]     = '0;
          exp_d[i]    = model(i, x_a[i], k_a[i]);
          if (pin_vld[i]) chk("model_pin", i, 256'(exp_d[i]), 256'(pin_val[i]));
        end
      end
    end
  end

  task automatic run(input int i, input logic [NB-1:0] x, input logic [NB-1:0] k);
    for (int n = 0; n < 200 && !ready_a[i]; n++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    x_a[i] = x; k_a[i] = k; start_a[i] = 1'b1;
    @(posedge clk); #1;
    start_a[i] = 1'b0;
    for (int n = 0; n < 3000 && busy[i]; n++) begin @(posedge clk); #1; end
    pin_vld[i] = 1'b0;
  endtask

  task automatic set_pin(input int i, input logic [NB-1:0] v, input int lat);
    pin_vld[i] = 1'b1; pin_val[i] = v; pin_lat[i] = lat;
  endtask

  initial begin
    logic [NB-1:0] rx, rk;
    for (int i = 0; i < 3; i++) begin
      start_a[i] = 1'b0; x_a[i] = '0; k_a[i] = '0; pin_vld[i] = 1'b0;
      pin_val[i] = '0; pin_lat[i] = 0;
      for (int r = 0; r < 8; r++) rc_tab[i][r] = '0;
    end
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // 5^5 = 3125 with one round.
    rc_tab[0][0] = 3;
`ifdef MIMC_FEEDFORWARD_EN
    set_pin(0, 'hC37, 19);
`else
    set_pin(0, 'hC35, 19);
`endif
    run(0, 2, 0);

    // Add wrap: (P-1)+1 reduces to 0.
    rc_tab[0][0] = 0;
`ifdef MIMC_FEEDFORWARD_EN
    set_pin(0, 0, 19);
`else
    set_pin(0, 1, 19);
`endif
    run(0, P - 1, 1);

    // Two rounds: x=1 after round 0, then (1+0+1)^5 = 32.
    rc_tab[1][0] = 0; rc_tab[1][1] = 1;
`ifdef MIMC_FEEDFORWARD_EN
    set_pin(1, 'h21, 36);
`else
    set_pin(1, 'h20, 36);
`endif
    run(1, 1, 0);

    // start held high through a run, x_in changed mid-run: must be ignored.
    rc_tab[0][0] = 7;
    @(posedge clk); #1;
    x_a[0] = 3; k_a[0] = 5; start_a[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1 x_a[0] = 9;
    for (int n = 0; n < 100 && !done_a[0]; n++) begin @(posedge clk); #1; end
    start_a[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Randomized runs across all instances.
    for (int n = 0; n < 9; n++) begin
      for (int r = 0; r < 8; r++) rc_tab[n % 3][r] = rnd();
      run(n % 3, rnd(), rnd());
    end
    run(2, P - 1, P - 1);
    run(1, 0, 0);

    // Reset at clock 10 of a run, then the same job again.
    for (int r = 0; r < 8; r++) rc_tab[2][r] = rnd();
    rx = rnd(); rk = rnd();
    @(posedge clk); #1;
    x_a[2] = rx; k_a[2] = rk; start_a[2] = 1'b1;
    @(posedge clk); #1;
    start_a[2] = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    run(2, rx, rk);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
